sound_fx: RTL and testbench

Sound-effect generator that consumes the game controller's event outputs (`hit`, `wall`, `goal`, `p1_win`, `p2_win`, `start_state`) and drives a single-bit square-wave speaker line. Each event starts a fixed-pitch, fixed-duration tone. A win starts a three-note rising jingle. Higher-priority events preempt lower-priority tones. The block sits between the game controller and the board's piezo or audio pin.

---
 rtl/sound_fx.sv | 171 +++++++++++++++++
 tb/tb_sound_fx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sound_fx.sv
// Sound-effect generator: event-triggered square-wave tones with priority preemption
// and a three-note win jingle on the rising edge of either win level.
module sound_fx #(
  parameter int unsigned TICK_DIV    = 25000,
  parameter int unsigned WALL_HALF   = 56818,
  parameter int unsigned HIT_HALF    = 28409,
  parameter int unsigned GOAL_HALF   = 18939,
  parameter int unsigned WIN_HALF0   = 23900,
  parameter int unsigned WIN_HALF1   = 18968,
  parameter int unsigned WIN_HALF2   = 15944,
  parameter int unsigned WALL_MS     = 30,
  parameter int unsigned HIT_MS      = 50,
  parameter int unsigned GOAL_MS     = 300,
  parameter int unsigned WIN_NOTE_MS = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit,
  input  logic       wall,
  input  logic       goal,
  input  logic       p1_win,
  input  logic       p2_win,
  input  logic       start_state,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [2:0] tone_id
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StTone = 2'd1;
  localparam logic [1:0] StWin  = 2'd2;

  localparam logic [16:0] WallHalf = 17'(WALL_HALF);
  localparam logic [16:0] HitHalf  = 17'(HIT_HALF);
  localparam logic [16:0] GoalHalf = 17'(GOAL_HALF);
  localparam logic [16:0] WinHalf0 = 17'(WIN_HALF0);
  localparam logic [16:0] WinHalf1 = 17'(WIN_HALF1);
  localparam logic [16:0] WinHalf2 = 17'(WIN_HALF2);
  localparam logic [8:0]  WallMs   = 9'(WALL_MS);
  localparam logic [8:0]  HitMs    = 9'(HIT_MS);
  localparam logic [8:0]  GoalMs   = 9'(GOAL_MS);
  localparam logic [8:0]  WinMs    = 9'(WIN_NOTE_MS);
  localparam logic [14:0] TickMax  = 15'(TICK_DIV - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  tone_q, tone_d;
  logic [1:0]  note_q, note_d;
  logic [16:0] half_q, half_d;
  logic [14:0] tick_q, tick_d;
  logic [8:0]  ms_q, ms_d;
  logic        spk_q, spk_d;
  logic        win_q;

  logic        win_any, win_edge;
  logic [2:0]  ev_prio, ev_id, cur_prio;
  logic [16:0] half_len, half_nxt;
  logic [8:0]  dur;
  logic        tick_wrap, tone_end, seq_end, accept;

  assign win_any  = p1_win | p2_win;
  assign win_edge = win_any & ~win_q;

  always_comb begin
    ev_prio = 3'd0;
    ev_id   = 3'd0;
    if (win_edge) begin
      ev_prio = 3'd4;
      ev_id   = 3'd4;
    end else if (goal) begin
      ev_prio = 3'd3;
      ev_id   = 3'd3;
    end else if (hit) begin
      ev_prio = 3'd2;
      ev_id   = 3'd2;
    end else if (wall) begin
      ev_prio = 3'd1;
      ev_id   = 3'd1;
    end
  end

  // Every win note shares the win priority.
  assign cur_prio = tone_q[2] ? 3'd4 : tone_q;

  always_comb begin
    half_len = 17'd1;
    dur      = WinMs;
    case (tone_q)
      3'd1: begin half_len = WallHalf; dur = WallMs; end
      3'd2: begin half_len = HitHalf;  dur = HitMs;  end
      3'd3: begin half_len = GoalHalf; dur = GoalMs; end
      3'd4: half_len = WinHalf0;
      3'd5: half_len = WinHalf1;
      3'd6: half_len = WinHalf2;
      default: half_len = 17'd1;
    endcase
  end

  assign half_nxt  = (half_q == half_len - 17'd1) ? 17'd0 : half_q + 17'd1;
  assign tick_wrap = (tick_q == TickMax);
  assign tone_end  = (state_q != StIdle) && tick_wrap && (ms_q == dur - 9'd1);
  assign seq_end   = tone_end && ((state_q == StTone) || (note_q == 2'd2));
  // Any event landing on the final cycle of a sequence takes over regardless of priority.
  assign accept    = (ev_prio != 3'd0) && ((ev_prio >= cur_prio) || seq_end);

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    note_d  = note_q;
    half_d  = half_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    spk_d   = spk_q;
    if (start_state || (!accept && (state_q == StIdle || seq_end))) begin
      state_d = StIdle;
      tone_d  = 3'd0;
      note_d  = 2'd0;
      half_d  = 17'd0;
      tick_d  = 15'd0;
      ms_d    = 9'd0;
      spk_d   = 1'b0;
    end else if (accept) begin
      state_d = (ev_id == 3'd4) ? StWin : StTone;
      tone_d  = ev_id;
      note_d  = 2'd0;
      half_d  = 17'd0;
      tick_d  = 15'd0;
      ms_d    = 9'd0;
      spk_d   = 1'b0;
    end else if (tone_end) begin
      note_d  = note_q + 2'd1;
      tone_d  = tone_q + 3'd1;
      half_d  = 17'd0;
      tick_d  = 15'd0;
      ms_d    = 9'd0;
      spk_d   = 1'b0;
    end else begin
      half_d = half_nxt;
      if (half_nxt == half_len - 17'd1) spk_d = ~spk_q;
      tick_d = tick_wrap ? 15'd0 : tick_q + 15'd1;
      if (tick_wrap) ms_d = ms_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      tone_q  <= 3'd0;
      note_q  <= 2'd0;
      half_q  <= 17'd0;
      tick_q  <= 15'd0;
      ms_q    <= 9'd0;
      spk_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      note_q  <= note_d;
      half_q  <= half_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      spk_q   <= spk_d;
      win_q   <= win_any;
    end
  end

  assign speaker = spk_q & ~mute;
  assign busy    = (state_q != StIdle);
  assign tone_id = tone_q;

endmodule

// File: tb/tb_sound_fx.sv
// Scoreboard bench for sound_fx: stimulus queues per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_sound_fx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit = 1'b0, wall = 1'b0, goal = 1'b0;
  logic       p1_win = 1'b0, p2_win = 1'b0, start_state = 1'b0, mute = 1'b0;
  logic       speaker, busy;
  logic [2:0] tone_id;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic       busy;
    logic [2:0] id;
    logic       spk;
    bit         chk_spk;
  } exp_t;

  exp_t sb[$];

  sound_fx #(
    .TICK_DIV(4), .WALL_HALF(6), .HIT_HALF(3), .GOAL_HALF(2),
    .WIN_HALF0(3), .WIN_HALF1(2), .WIN_HALF2(1),
    .WALL_MS(2), .HIT_MS(3), .GOAL_MS(5), .WIN_NOTE_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .hit(hit), .wall(wall), .goal(goal),
    .p1_win(p1_win), .p2_win(p2_win), .start_state(start_state), .mute(mute),
    .speaker(speaker), .busy(busy), .tone_id(tone_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Tone segment: speaker first toggles HALF-1 cycles after the tone's first cycle,
  // then every HALF cycles.
  task automatic exp_seg(input int start, input int from, input int to, input logic [2:0] id,
                         input int half, input bit muted, input bit cs);
    for (int c = from; c <= to; c++) begin
      int   i;
      int   n;
      exp_t e;
      i = c - start;
      n = (i >= half - 1) ? (i - (half - 1)) / half + 1 : 0;
      e.cyc = c;
      e.busy = 1'b1;
      e.id = id;
      e.spk = muted ? 1'b0 : n[0];
      e.chk_spk = cs;
      sb.push_back(e);
    end
  endtask

  task automatic exp_idle(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      exp_t e;
      e.cyc = c;
      e.busy = 1'b0;
      e.id = 3'd0;
      e.spk = 1'b0;
      e.chk_spk = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          chk("missed_expectation", e.cyc, cyc);
        end else begin
          chk("busy", int'(busy), int'(e.busy));
          chk("tone_id", int'(tone_id), int'(e.id));
          if (e.chk_spk) chk("speaker", int'(speaker), int'(e.spk));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 rst = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_tone_id", int'(tone_id), 0);
    chk("reset_speaker", int'(speaker), 0);
    exp_idle(1, 10);
    wait_to(3);
    rst = 1'b1;

    // Test 1: hit tone, toggles at 13/16/19/22
    exp_seg(11, 11, 22, 3'd2, 3, 1'b0, 1'b1);
    exp_idle(23, 29);
    wait_to(10); hit = 1'b1;
    wait_to(11); hit = 1'b0;

    // Test 2: wall+hit together, ignored wall, restart by hit
    exp_seg(31, 31, 36, 3'd2, 3, 1'b0, 1'b1);
    exp_seg(37, 37, 48, 3'd2, 3, 1'b0, 1'b1);
    exp_idle(49, 55);
    wait_to(30); wall = 1'b1; hit = 1'b1;
    wait_to(31); wall = 1'b0; hit = 1'b0;
    wait_to(33); wall = 1'b1;
    wait_to(34); wall = 1'b0;
    wait_to(36); hit = 1'b1;
    wait_to(37); hit = 1'b0;

    // Test 3: win preempts goal, three notes, no retrigger while held
    exp_seg(61, 61, 65, 3'd3, 2, 1'b0, 1'b1);
    exp_seg(66, 66, 73, 3'd4, 3, 1'b0, 1'b1);
    exp_seg(74, 74, 81, 3'd5, 2, 1'b0, 1'b1);
    exp_seg(82, 82, 89, 3'd6, 1, 1'b0, 1'b0);
    exp_idle(90, 115);
    wait_to(60); goal = 1'b1;
    wait_to(61); goal = 1'b0;
    wait_to(65); p1_win = 1'b1;
    wait_to(111); p1_win = 1'b0;

    // Test 4: muted hit
    exp_seg(131, 131, 142, 3'd2, 3, 1'b1, 1'b1);
    exp_idle(143, 148);
    wait_to(120); mute = 1'b1;
    wait_to(130); hit = 1'b1;
    wait_to(131); hit = 1'b0;
    wait_to(150); mute = 1'b0;

    // Test 5: start_state aborts goal and blocks a hit
    exp_seg(161, 161, 165, 3'd3, 2, 1'b0, 1'b1);
    exp_idle(166, 180);
    wait_to(160); goal = 1'b1;
    wait_to(161); goal = 1'b0;
    wait_to(165); start_state = 1'b1;
    wait_to(170); hit = 1'b1;
    wait_to(171); hit = 1'b0;
    wait_to(176); start_state = 1'b0;

    // Test 6: asynchronous reset mid-jingle, then a wall tone
    exp_seg(191, 191, 198, 3'd4, 3, 1'b0, 1'b1);
    exp_seg(199, 199, 199, 3'd5, 2, 1'b0, 1'b1);
    exp_idle(200, 210);
    exp_seg(211, 211, 218, 3'd1, 6, 1'b0, 1'b1);
    exp_idle(219, 225);
    wait_to(190); p2_win = 1'b1;
    wait_to(200);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_tone_id", int'(tone_id), 0);
    chk("async_reset_speaker", int'(speaker), 0);
    wait_to(201); p2_win = 1'b0;
    wait_to(203); rst = 1'b1;
    wait_to(210); wall = 1'b1;
    wait_to(211); wall = 1'b0;

    // Event on the final cycle of a tone takes over next cycle
    exp_seg(231, 231, 242, 3'd2, 3, 1'b0, 1'b1);
    exp_seg(243, 243, 250, 3'd1, 6, 1'b0, 1'b1);
    exp_idle(251, 255);
    wait_to(230); hit = 1'b1;
    wait_to(231); hit = 1'b0;
    wait_to(242); wall = 1'b1;
    wait_to(243); wall = 1'b0;

    wait_to(260);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
